// File: rtl/clock_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// clock_pkg: state encoding, field indices, BCD limits  (rev 1.0)
// ------------------------------------------------------------------
package clock_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } state_t;

    localparam int SEC = 0;
    localparam int MIN = 1;
    localparam int HR  = 2;

    localparam logic [7:0] SEC_MAX = 8'h59;
    localparam logic [7:0] MIN_MAX = 8'h59;
    localparam logic [7:0] HR_MAX  = 8'h23;

endpackage
`default_nettype wire

// File: rtl/bcd_field_counter.sv
`default_nettype none
// ------------------------------------------------------------------
// bcd_field_counter: packed-BCD counter 00..MAX with wrap pulse  (rev 1.0)
// ------------------------------------------------------------------
module bcd_field_counter #(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       carry_en,
    output logic [7:0] value,
    output logic       wrap
);

    logic at_max;

    assign at_max = (value == MAX);
    // Combinational so the next field can advance on the same edge.
    assign wrap   = inc & carry_en & at_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= 8'h00;
        end else if (inc) begin
            if (at_max)
                value <= 8'h00;
            else if (value[3:0] == 4'd9)
                value <= {value[7:4] + 4'd1, 4'd0};
            else
                value <= value + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// clock_set_ctrl: BCD time-of-day with mode/inc key set and timeout  (rev 1.0)
// ------------------------------------------------------------------
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int TIMEOUT_S = 30
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Tick1Hz,
    input  logic       BlinkTick,
    input  logic       ModeKey,
    input  logic       IncKey,
    output logic [7:0] Seconds,
    output logic [7:0] Minutes,
    output logic [7:0] Hours,
    output logic [1:0] Mode,
    output logic [2:0] FieldBlank
);

    state_t     state, state_nxt;
    logic [7:0] idle, idle_nxt;
    logic       blink, blink_nxt;
    logic [2:0] blank_nxt;
    logic       in_set, run_tick, edit_inc, any_key;
    logic       sec_wrap, min_wrap, hr_wrap_unused;

    assign in_set   = (state != RUN);
    assign run_tick = Tick1Hz & ~in_set;
    assign any_key  = ModeKey | IncKey;
    // ModeKey wins over IncKey on the same edge.
    assign edit_inc = IncKey & ~ModeKey & in_set;

    always_comb begin
        state_nxt = state;
        idle_nxt  = idle;
        blink_nxt = blink;
        blank_nxt = 3'b000;

        if (ModeKey) begin
            case (state)
                RUN:     state_nxt = SET_HR;
                SET_HR:  state_nxt = SET_MIN;
                SET_MIN: state_nxt = SET_SEC;
                default: state_nxt = RUN;
            endcase
        end

        if (any_key || !in_set) begin
            idle_nxt = 8'd0;
        end else if (Tick1Hz) begin
            if (idle + 8'd1 == 8'(TIMEOUT_S)) begin
                state_nxt = RUN;
                idle_nxt  = 8'd0;
            end else begin
                idle_nxt  = idle + 8'd1;
            end
        end

        if (any_key)
            blink_nxt = 1'b0;
        else if (BlinkTick)
            blink_nxt = ~blink;

        case (state_nxt)
            SET_HR:  blank_nxt[HR]  = blink_nxt;
            SET_MIN: blank_nxt[MIN] = blink_nxt;
            SET_SEC: blank_nxt[SEC] = blink_nxt;
            default: blank_nxt      = 3'b000;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= RUN;
            idle       <= 8'd0;
            blink      <= 1'b0;
            FieldBlank <= 3'b000;
        end else begin
            state      <= state_nxt;
            idle       <= idle_nxt;
            blink      <= blink_nxt;
            FieldBlank <= blank_nxt;
        end
    end

    assign Mode = state;

    bcd_field_counter #(.MAX(SEC_MAX)) u_sec (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .inc      (run_tick | (edit_inc & (state == SET_SEC))),
        .carry_en (run_tick),
        .value    (Seconds),
        .wrap     (sec_wrap)
    );

    bcd_field_counter #(.MAX(MIN_MAX)) u_min (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .inc      (sec_wrap | (edit_inc & (state == SET_MIN))),
        .carry_en (~in_set),
        .value    (Minutes),
        .wrap     (min_wrap)
    );

    bcd_field_counter #(.MAX(HR_MAX)) u_hr (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .inc      (min_wrap | (edit_inc & (state == SET_HR))),
        .carry_en (~in_set),
        .value    (Hours),
        .wrap     (hr_wrap_unused)
    );

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_clock_set_ctrl: scoreboard bench with time-of-day reference model  (rev 1.0)
// ------------------------------------------------------------------
module tb_clock_set_ctrl;

    localparam int TO = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0, btick = 1'b0, mkey = 1'b0, ikey = 1'b0;
    logic [7:0] sec, min, hr;
    logic [1:0] mode;
    logic [2:0] blank;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] s;
        logic [7:0] m;
        logic [7:0] h;
        logic [1:0] mode;
        logic [2:0] blank;
    } exp_t;

    exp_t sb[$];

    int m_h, m_m, m_s, m_mode, m_idle;
    bit m_blink;

    clock_set_ctrl #(.TIMEOUT_S(TO)) dut (
        .Clk        (clk),
        .Rst_n      (rst_n),
        .Tick1Hz    (tick),
        .BlinkTick  (btick),
        .ModeKey    (mkey),
        .IncKey     (ikey),
        .Seconds    (sec),
        .Minutes    (min),
        .Hours      (hr),
        .Mode       (mode),
        .FieldBlank (blank)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int x);
        return 8'(((x / 10) * 16) + (x % 10));
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_idle = 0; m_blink = 0;
    endtask

    // Reference: whole-day seconds arithmetic for RUN, modular field edits in SET.
    task automatic model_step(input bit t, input bit bt, input bit mk, input bit ik);
        int   old;
        int   tot;
        exp_t e;
        old = m_mode;
        if (mk) m_mode = (m_mode + 1) % 4;
        if (old == 0 && t) begin
            tot = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
            m_h = tot / 3600;
            m_m = (tot / 60) % 60;
            m_s = tot % 60;
        end
        if (!mk && ik && old != 0) begin
            if (old == 1) m_h = (m_h + 1) % 24;
            else if (old == 2) m_m = (m_m + 1) % 60;
            else m_s = (m_s + 1) % 60;
        end
        if (mk || ik) m_idle = 0;
        else if (old != 0 && t) begin
            m_idle++;
            if (m_idle == TO) begin
                m_mode = 0;
                m_idle = 0;
            end
        end
        if (mk || ik) m_blink = 0;
        else if (bt) m_blink = ~m_blink;
        e.s = bcd(m_s);
        e.m = bcd(m_m);
        e.h = bcd(m_h);
        e.mode = 2'(m_mode);
        e.blank = (m_mode == 0) ? 3'b000 :
                  (m_mode == 1) ? {m_blink, 2'b00} :
                  (m_mode == 2) ? {1'b0, m_blink, 1'b0} : {2'b00, m_blink};
        sb.push_back(e);
    endtask

    task automatic cyc(input bit t, input bit bt, input bit mk, input bit ik);
        @(negedge clk);
        tick = t; btick = bt; mkey = mk; ikey = ik;
        model_step(t, bt, mk, ik);
    endtask

    task automatic incs(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        tick = 0; btick = 0; mkey = 0; ikey = 0;
        rst_n = 1'b0;
        #2;
        check("rst_sec", sec, 8'h00);
        check("rst_mode", {6'd0, mode}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Monitor: every edge is an output event; compare against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("seconds", sec, e.s);
                check("minutes", min, e.m);
                check("hours", hr, e.h);
                check("mode", {6'd0, mode}, {6'd0, e.mode});
                check("blank", {5'd0, blank}, {5'd0, e.blank});
            end
        end
    end

    initial begin
        model_reset();
        do_reset();
        cyc(0, 0, 0, 0);

        // 61 seconds in RUN
        for (int i = 0; i < 61; i++) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);

        // preload 23:59:59 and roll over
        cyc(0, 0, 1, 0); incs(23);
        cyc(0, 0, 1, 0); incs(58);
        cyc(0, 0, 1, 0); incs(58);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);

        // 25 hour increments wrap without carry
        cyc(0, 0, 1, 0); incs(25);
        // SET_MIN: ModeKey+IncKey together, then a blink
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);

        // timeout from SET_HR; ModeKey+Tick in RUN
        cyc(1, 0, 1, 0);
        cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        // ModeKey+Tick in SET_SEC returns to RUN without incrementing
        cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
        cyc(1, 0, 1, 0);

        // 12:34:56 in SET_SEC, then asynchronous reset between edges
        do_reset();
        cyc(0, 0, 1, 0); incs(12);
        cyc(0, 0, 1, 0); incs(34);
        cyc(0, 0, 1, 0); incs(56);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sec", sec, 8'h00);
        check("arst_min", min, 8'h00);
        check("arst_hr", hr, 8'h00);
        check("arst_mode", {6'd0, mode}, 8'h00);
        check("arst_blank", {5'd0, blank}, 8'h00);
        #1;
        rst_n = 1'b1;
        model_reset();
        cyc(1, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0));
        end
        for (int i = 0; i < 1500; i++) begin
            cyc(1'b1, 1'b0, ($urandom_range(0, 99) == 0), 1'b0);
        end
        cyc(0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        check("sb_drained", 8'(sb.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
